// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the pipelined integer ALU.
//   alu_op_e     : 3-bit opcode enumeration
//   FLAG_*       : bit positions of the flags inside the 5-bit flags vector
//   alu_flags_t  : packed flags, MSB..LSB = {SF, ZF, OF, AF, CF}
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'd0,
        OP_OR    = 3'd1,
        OP_BSF   = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_AND   = 3'd5,
        OP_XOR   = 3'd6,
        OP_ADC   = 3'd7
    } alu_op_e;

    localparam int FLAG_CF = 0;
    localparam int FLAG_AF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 4;

    typedef struct packed {
        logic sf;
        logic zf;
        logic of;
        logic af;
        logic cf;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational ALU datapath for alu_pipe.
// Ports:
//   op       in  opcode
//   a, b     in  WIDTH-bit operands
//   cf_in    in  carry-in used by ADC only
//   flags_in in  architectural flags, used by ops that preserve flags
//   result   out WIDTH-bit result
//   flags    out flags produced by this op
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cf_in,
    input  alu_flags_t         flags_in,
    output logic [WIDTH-1:0]   result,
    output alu_flags_t         flags
);

    logic             carry_in_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [IDX_W-1:0] bsf_idx_s;

    // Flags for the bitwise ops: CF/AF/OF cleared, ZF/SF from the result.
    function automatic alu_flags_t logic_flags(input logic [WIDTH-1:0] r);
        alu_flags_t f;
        f.sf = r[WIDTH-1];
        f.zf = (r == {WIDTH{1'b0}});
        f.of = 1'b0;
        f.af = 1'b0;
        f.cf = 1'b0;
        return f;
    endfunction

    // Adder/subtractor with an extra MSB to capture carry/borrow out.
    always_comb begin
        carry_in_s = (op == OP_ADC) ? cf_in : 1'b0;
        sum_s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in_s};
        diff_s     = {1'b0, a} - {1'b0, b};
    end

    // Lowest-set-bit scan: walking downward lets the lowest hit win.
    always_comb begin
        bsf_idx_s = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bsf_idx_s = a[i] ? IDX_W'(i) : bsf_idx_s;
        end
    end

    // Result and flag selection per opcode.
    always_comb begin
        result = {WIDTH{1'b0}};
        flags  = flags_in;
        case (op)
            OP_PASSB: begin
                result = b;
                flags  = flags_in;
            end
            OP_OR: begin
                result = a | b;
                flags  = logic_flags(a | b);
            end
            OP_AND: begin
                result = a & b;
                flags  = logic_flags(a & b);
            end
            OP_XOR: begin
                result = a ^ b;
                flags  = logic_flags(a ^ b);
            end
            OP_BSF: begin
                result   = {{(WIDTH-IDX_W){1'b0}}, bsf_idx_s};
                flags    = flags_in;
                flags.zf = (a == {WIDTH{1'b0}});
            end
            OP_ADD, OP_ADC: begin
                result   = sum_s[WIDTH-1:0];
                flags.cf = sum_s[WIDTH];
                // Carry into bit 4 recovered from the operand and sum bits.
                flags.af = a[4] ^ b[4] ^ sum_s[4];
                flags.of = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
                flags.zf = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
                flags.sf = sum_s[WIDTH-1];
            end
            OP_SUB: begin
                result   = diff_s[WIDTH-1:0];
                flags.cf = diff_s[WIDTH];
                flags.af = a[4] ^ b[4] ^ diff_s[4];
                flags.of = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
                flags.zf = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
                flags.sf = diff_s[WIDTH-1];
            end
            default: begin
                result = {WIDTH{1'b0}};
                flags  = flags_in;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes and an
// architectural flags register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous kill of both stages
//   in_valid/in_ready    input handshake; in_op, in_a, in_b, in_flags_we
//   out_valid/out_ready  output handshake; out_result, out_flags
//   flags                architectural flags {SF,ZF,OF,AF,CF}
// Build option: ALU_PIPE_ADC_EN enables ADC with carry forwarding from S2;
// without it opcode 7 behaves as ADD.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_flags_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_flags,
    output logic [4:0]       flags
);

    logic             s1_valid_q, s1_valid_d;
    alu_op_e          s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_we_q, s1_we_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    alu_flags_t       s2_flags_q, s2_flags_d;
    logic             s2_we_q, s2_we_d;

    alu_flags_t       flags_q, flags_d;

    logic             s1_adv_s, s2_adv_s, accept_s, commit_s, cf_eff_s;
    logic [WIDTH-1:0] core_result_s;
    alu_flags_t       core_flags_s;

    // Pipeline advance, acceptance and flag-commit conditions.
    always_comb begin
        s2_adv_s = ~s2_valid_q | out_ready;
        s1_adv_s = ~s1_valid_q | s2_adv_s;
        accept_s = in_valid & s1_adv_s & ~flush;
        commit_s = s2_valid_q & out_ready & s2_we_q;
    end

    // Carry seen by ADC: an uncommitted flag-writing op in S2 is younger
    // than the flags register, so its carry takes priority.
    always_comb begin
`ifdef ALU_PIPE_ADC_EN
        cf_eff_s = (s2_valid_q & s2_we_q) ? s2_flags_q.cf : flags_q.cf;
`else
        cf_eff_s = 1'b0;
`endif
    end

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .cf_in    (cf_eff_s),
        .flags_in (flags_q),
        .result   (core_result_s),
        .flags    (core_flags_s)
    );

    // S1 next state: capture an accepted op, empty on flush.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_we_d    = s1_we_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_op_d = alu_op_e'(in_op);
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_we_d = in_flags_we;
            end else begin
                s1_op_d = s1_op_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: take the ALU output when S2 may advance.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_we_d     = s2_we_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result_s;
                s2_flags_d  = core_flags_s;
                s2_we_d     = s1_we_q;
            end else begin
                s2_we_d = s2_we_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Architectural flags update; commits even in a flush cycle.
    always_comb begin
        if (commit_s) begin
            flags_d = s2_flags_q;
        end else begin
            flags_d = flags_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_PASSB;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_we_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= {WIDTH{1'b0}};
            s2_flags_q  <= 5'b00000;
            s2_we_q     <= 1'b0;
            flags_q     <= 5'b00000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_we_q     <= s1_we_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_we_q     <= s2_we_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready   = s1_adv_s & ~flush;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        in_flags_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  flags;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_flags_we(in_flags_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .flags(flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU; flags packed {SF,ZF,OF,AF,CF}, result in the low 32 bits.
    function automatic logic [36:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cf,
                                            input logic [4:0] fin);
        logic [31:0] res;
        logic [4:0]  f;
        logic        cin;
        longint unsigned wide;
        longint      sa, sb, sr;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        f   = fin;
        res = 32'd0;
        cin = 1'b0;
        case (op)
            3'd0: res = b;
            3'd1, 3'd5, 3'd6: begin
                res = (op == 3'd1) ? (a | b) : (op == 3'd5) ? (a & b) : (a ^ b);
                f   = {res[31], (res == 32'd0), 3'b000};
            end
            3'd2: begin
                res = 32'd0;
                for (int i = 31; i >= 0; i--) if (a[i]) res = 32'(i);
                f[3] = (a == 32'd0);
            end
            3'd3, 3'd7: begin
                cin  = (op == 3'd7) ? cf : 1'b0;
                wide = longint'(a) + longint'(b) + longint'(cin);
                res  = a + b + 32'(cin);
                sr   = sa + sb + longint'(cin);
                f    = {res[31], (res == 32'd0), (sr > 64'sd2147483647 || sr < -64'sd2147483648),
                        ((a & 32'd15) + (b & 32'd15) + 32'(cin)) > 32'd15, wide > 64'hFFFF_FFFF};
            end
            default: begin
                res = a - b;
                sr  = sa - sb;
                f   = {res[31], (res == 32'd0), (sr > 64'sd2147483647 || sr < -64'sd2147483648),
                       (a & 32'd15) < (b & 32'd15), a < b};
            end
        endcase
        return {f, res};
    endfunction

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic we; } op_t;

    op_t         acc_q[$];
    op_t         head;
    logic [31:0] cur_res = 32'd0;
    logic [4:0]  cur_flg = 5'd0;
    logic        cur_we = 1'b0;
    logic [4:0]  model_arch = 5'd0;
    logic [4:0]  snap = 5'd0;
    logic        last_we_cf = 1'b0;
    logic        adc_cin;
    logic        appear_pending = 1'b0;
    int          outstanding = 0;
    int          n_deliv = 0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_flg = 5'd0;

    // Scoreboard: ops execute in acceptance order; preserving ops read the
    // architectural flags as they stood just before the op reached the output.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            model_arch = 5'd0; snap = 5'd0; last_we_cf = 1'b0;
            appear_pending = 1'b0; outstanding = 0;
        end else begin
            if (appear_pending && out_valid) begin
                if (acc_q.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    head = acc_q.pop_front();
`ifdef ALU_PIPE_ADC_EN
                    adc_cin = last_we_cf;
`else
                    adc_cin = 1'b0;
`endif
                    {cur_flg, cur_res} = ref_alu(head.op, head.a, head.b, adc_cin, snap);
                    cur_we = head.we;
                    if (head.we) last_we_cf = cur_flg[0];
                end
            end
            if (out_valid) begin
                check("out_result", out_result, cur_res);
                check("out_flags", out_flags, cur_flg);
            end
            check("arch_flags", flags, model_arch);
            appear_pending = (!out_valid || out_ready) && !flush;
            snap = model_arch;
            if (out_valid && out_ready) begin
                n_deliv++; outstanding--;
                last_res = out_result; last_flg = out_flags;
                if (cur_we) model_arch = cur_flg;
            end
            if (in_valid && in_ready) begin
                acc_q.push_back('{op: in_op, a: in_a, b: in_b, we: in_flags_we});
                outstanding++;
            end
            if (flush) begin
                acc_q.delete();
                outstanding = 0;
                last_we_cf = model_arch[0];
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic we);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_flags_we = we;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk); #1 acc = in_ready;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((outstanding != 0 || out_valid) && t < 100) begin
            @(posedge clk); #2;
            t++;
        end
        check("drain_done", (t < 100), 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] hold_res;
    logic [4:0]  arch_before;
    logic [31:0] adc_exp;
    int          d0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", out_flags, 5'd0);
        check("rst_flags", flags, 5'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #2;

        // Directed cases from the test plan.
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1); drain();
        check("add_res", last_res, 32'h8000_0000);
        check("add_flags", last_flg, 5'b10110);
        send(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b1); drain();
        check("sub_res", last_res, 32'hFFFF_FFFF);
        check("sub_flags", last_flg, 5'b10011);
        send(OP_BSF, 32'h0000_0500, 32'h0, 1'b1); drain();
        check("bsf_res", last_res, 32'd8);
        check("bsf_zf", last_flg[3], 1'b0);
        send(OP_BSF, 32'h0, 32'h0, 1'b1); drain();
        check("bsf0_res", last_res, 32'd0);
        check("bsf0_zf", last_flg[3], 1'b1);
        check("bsf0_keep", {last_flg[4], last_flg[2:0]}, 4'b1011);

        // ADD producing carry, immediately followed by ADC.
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
        send(OP_ADC, 32'h0, 32'h0, 1'b1);
        drain();
`ifdef ALU_PIPE_ADC_EN
        adc_exp = 32'd1;
`else
        adc_exp = 32'd0;
`endif
        check("adc_chain", last_res, adc_exp);

        // Backpressure: four ops with the consumer stalled.
        d0 = n_deliv;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_ADD; in_a = $urandom; in_b = $urandom; in_flags_we = 1'b1;
        @(negedge clk); #1 check("bp_ready_0", in_ready, 1'b1);
        @(posedge clk); #2;
        in_op = OP_XOR; in_a = $urandom; in_b = $urandom; in_flags_we = 1'b0;
        @(negedge clk); #1 check("bp_ready_1", in_ready, 1'b1);
        @(posedge clk); #2;
        in_op = OP_SUB; in_a = $urandom; in_b = $urandom; in_flags_we = 1'b1;
        @(negedge clk); #1 check("bp_ready_full", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        hold_res = out_result;
        @(posedge clk); #2;
        @(negedge clk); #1 check("bp_hold", out_result, hold_res);
        check("bp_ready_still", in_ready, 1'b0);
        @(posedge clk); #2;
        out_ready = 1'b1;
        send(in_op, in_a, in_b, in_flags_we);
        send(OP_OR, $urandom, $urandom, 1'b1);
        drain();
        check("bp_count", n_deliv - d0, 4);

        // Flush with both stages full and the consumer stalled.
        out_ready = 1'b0;
        send(OP_ADD, $urandom, $urandom, 1'b1);
        send(OP_SUB, $urandom, $urandom, 1'b1);
        arch_before = model_arch;
        flush = 1'b1;
        @(negedge clk); #1 check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #2 flush = 1'b0;
        @(negedge clk); #1 check("flush_out_valid", out_valid, 1'b0);
        check("flush_flags", flags, arch_before);
        @(posedge clk); #2;

        // Flush in the same cycle the S2 op commits.
        send(OP_AND, 32'h8000_00F0, 32'hF000_0010, 1'b1);
        @(posedge clk); #2;
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        @(negedge clk); #1 check("flush_commit", flags, 5'b10000);
        check("flush_commit_valid", out_valid, 1'b0);
        @(posedge clk); #2;

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_op       = 3'($urandom_range(0, 7));
            in_a        = pick();
            in_b        = pick();
            in_flags_we = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with ops in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_op = OP_ADD; in_a = $urandom; in_b = $urandom; in_flags_we = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_flags", out_flags, 5'd0);
        check("arst_flags", flags, 5'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(OP_ADD, 32'd1, 32'd2, 1'b0); drain();
        check("post_rst_add", last_res, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
